// File: rtl/foo_x_capture.sv
// Capture stage behind the foo wrapper: samples x_in, stamps it with a cycle counter,
// and queues it in a first-word-fall-through FIFO that drains over valid/ready.
module foo_x_capture #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int TS_W        = 16,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         cap_en,
  input  logic [DATA_W-1:0]            x_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [TS_W-1:0]              out_ts,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TS_W-1:0]   ts;
  logic [DATA_W-1:0] last_x;
  logic              first;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_x  [DEPTH];
  logic [TS_W-1:0]   mem_ts [DEPTH];

  logic empty;
  logic full;
  logic req;
  logic pop;
  logic push;
  logic drop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign req   = cap_en && (!CHANGE_ONLY || first || (x_in != last_x));
  assign pop   = out_valid && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push  = req && !clear && (!full || pop);
  assign drop  = req && !clear && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      last_x   <= '0;
      first    <= 1'b1;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      first    <= 1'b1;
      if (cap_en) last_x <= x_in;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
      if (cap_en) begin
        last_x <= x_in;
        first  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr]  <= x_in;
      mem_ts[wr_ptr] <= ts;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_x[rd_ptr];
  assign out_ts    = empty ? '0 : mem_ts[rd_ptr];

endmodule

// File: doc/foo_x_capture.md
Name: foo_x_capture

Overview:
- Downstream stage of the foo DPI black-box wrapper.
- Samples foo's 32-bit result output `x` every `clk` edge and optionally filters to value changes only.
- Tags each captured sample with a free-running cycle timestamp and buffers it in a first-word-fall-through FIFO.
- Drains to the bench/scoreboard over a valid/ready interface and records overflow drops.

Parameters:
- DATA_W, 32, width of the captured `x` value.
- DEPTH, 8, FIFO entries; power of two, ≥2.
- TS_W, 16, timestamp counter width.
- CHANGE_ONLY, 1, 1 = push only on value change or first sample; 0 = push every enabled cycle.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush: empties FIFO, zeroes drop_cnt/overflow, re-arms first-sample.
- cap_en  in  1  capture enable, sampled each edge.
- x_in  in  DATA_W  foo result `x`.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_W  head value; 0 when empty.
- out_ts  out  TS_W  head timestamp; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: at least one push dropped since reset/clear.
- drop_cnt  out  16  dropped-push count, saturating at 0xFFFF.

Behaviour:
- Reset (rst=1, async): FIFO empty, count=0, out_valid=0, out_data=0, out_ts=0, overflow=0, drop_cnt=0, ts=0, last_x=0, first=1.
- ts: increments by 1 every edge while not in reset; wraps 2^TS_W−1 → 0. It is not affected by clear.
- Capture request at edge when cap_en=1:
  - CHANGE_ONLY=0: request every such edge.
  - CHANGE_ONLY=1: request only if first=1 or x_in≠last_x.
- On every cap_en=1 edge, last_x←x_in and first←0, whether or not the push succeeded.
- Pushed entry = {x_in, ts value at that edge, pre-increment}.
- Pop = out_valid & out_ready at the edge. out_data/out_ts reflect the FIFO head combinationally from storage (FWFT).
- Latency: sample at edge N into an empty FIFO → out_valid=1 after edge N, with that entry at the head.
- Full (count=DEPTH):
  - request without pop → entry dropped, overflow←1, drop_cnt+1 (saturating).
  - request with simultaneous pop → both occur, count stays DEPTH, no drop.
- Empty: a pop cannot occur because out_valid=0. Simultaneous push into empty → count 1.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count.
- clear=1 has priority over push and pop in the same cycle:
  - after the edge: count=0, overflow=0, drop_cnt=0, first=1.
  - a request in that cycle is discarded and not counted as a drop.
- rst asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- No combinational path from x_in/cap_en to outputs; out_* depend on out_ready only through the registered pop.

Test Plan:
- Reset release, CHANGE_ONLY=1, cap_en=1, x_in held 0x0000_00AA for 5 cycles, out_ready=1 → exactly one entry {0xAA, ts=0}; count returns to 0; drop_cnt=0.
- CHANGE_ONLY=1, x_in sequence 1,1,2,2,3 on consecutive edges, out_ready=0 → count=3, drained as (1,t0),(2,t0+2),(3,t0+4).
- DEPTH=8, CHANGE_ONLY=0, out_ready=0, cap_en=1 for 11 cycles → count=8, overflow=1, drop_cnt=3; draining gives the first 8 samples in order.
- Full FIFO with out_ready=1 and cap_en=1 for 4 cycles → count stays 8, drop_cnt unchanged, pushed values appear after the prior 8.
- clear asserted in the same cycle as a push and a pop with count=5 → count=0, out_valid=0, drop_cnt=0; the next differing x_in is captured as a first sample.
- TS_W=4, run past 16 cycles with CHANGE_ONLY=0 → out_ts wraps 15→0; assert async rst mid-burst → out_valid drops to 0 before the next clk edge.
